// File: rtl/fir_symmetric_mc.sv
// fir_symmetric_mc: multi-channel symmetric FIR with one folded pre-add/multiply/accumulate per cycle.
// Build option FIR_SATURATE_EN: clamp results to WIDTH bits instead of two's-complement wrap.
module fir_symmetric_mc #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int N_CH   = 2,
  parameter int FRAC   = 15,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int HALF  = TAPS / 2,
  localparam int K_W   = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                coef_we,
  input  logic [K_W-1:0]      coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_data,
  output logic                err
);
  localparam int TAP_W  = $clog2(TAPS);
  localparam int PROD_W = WIDTH + 1 + COEF_W;
  localparam int ACC_W  = WIDTH + 1 + COEF_W + $clog2(HALF) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                              state_q, state_d;
  logic [K_W-1:0]                      k_q, k_d;
  logic [CH_W-1:0]                     ch_q, ch_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [WIDTH-1:0]                    out_data_q, out_data_d;
  logic                                err_q, err_d;
  logic [HALF-1:0][COEF_W-1:0]         coef_q, coef_d;
  logic [N_CH-1:0][TAPS-1:0][WIDTH-1:0] line_q, line_d;

  logic [TAP_W-1:0]                    idx_a_s, idx_b_s;
  logic signed [WIDTH:0]               pre_add_s;
  logic signed [PROD_W-1:0]            prod_s;
  logic signed [ACC_W-1:0]             acc_sum_s;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  function automatic logic [WIDTH-1:0] scale(input logic signed [ACC_W-1:0] acc);
`ifdef FIR_SATURATE_EN
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX) begin
      scale = SAT_MAX[WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      scale = SAT_MIN[WIDTH-1:0];
    end else begin
      scale = sh[WIDTH-1:0];
    end
`else
    scale = WIDTH'(acc >>> FRAC);
`endif
  endfunction

  // Folded tap pair x[k] + x[TAPS-1-k] of the latched channel, weighted by c[k]
  always_comb begin
    idx_a_s   = TAP_W'(k_q);
    idx_b_s   = TAP_W'(TAPS - 1) - idx_a_s;
    pre_add_s = (WIDTH+1)'($signed(line_q[ch_q][idx_a_s])) + (WIDTH+1)'($signed(line_q[ch_q][idx_b_s]));
    prod_s    = PROD_W'(pre_add_s) * PROD_W'($signed(coef_q[k_q]));
    acc_sum_s = acc_q + ACC_W'(prod_s);
  end

  // Next-state and register-update logic for the IDLE -> MAC -> OUT sequence
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;
    coef_d     = coef_q;
    line_d     = line_q;
    case (state_q)
      IDLE: begin
        // The coefficient write lands on the same edge as an accept, so MAC sees the new value
        if (coef_we) begin
          if (int'(coef_addr) < HALF) begin
            coef_d[coef_addr] = coef_data;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          coef_d = coef_q;
        end
        if (in_valid) begin
          if (int'(in_ch) < N_CH) begin
            for (int t = TAPS - 1; t > 0; t--) begin
              line_d[in_ch][t] = line_q[in_ch][t-1];
            end
            line_d[in_ch][0] = in_data;
            ch_d    = in_ch;
            k_d     = {K_W{1'b0}};
            acc_d   = {ACC_W{1'b0}};
            state_d = MAC;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_sum_s;
        err_d = coef_we;
        if (k_q == K_W'(HALF - 1)) begin
          out_data_d = scale(acc_sum_s);
          state_d    = OUT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      OUT: begin
        err_d = coef_we;
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= {K_W{1'b0}};
      ch_q       <= {CH_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      out_data_q <= {WIDTH{1'b0}};
      err_q      <= 1'b0;
      coef_q     <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      coef_q     <= coef_d;
      line_q     <= line_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_ch    = ch_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule
